// File: rtl/cgra_stream_pkg.sv
// Shared definitions for CGRA stream stages (fork, join, merge).
package cgra_stream_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int MAX_FORK_OUT       = 8;

  typedef enum logic {
    FORK_EMPTY = 1'b0,
    FORK_HOLD  = 1'b1
  } fork_state_e;

  // True when every lane is either already served or served this cycle.
  // Callers tie unused upper lanes of `sent` to 1 so they never block.
  function automatic logic all_served(input logic [MAX_FORK_OUT-1:0] sent,
                                      input logic [MAX_FORK_OUT-1:0] served_now);
    return &(sent | served_now);
  endfunction

endpackage

// File: rtl/d_fork_eager_if.sv
// Handshake bundle for the eager fork: upstream token port plus fan-out port.
interface d_fork_eager_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 2
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_v;
  logic                  din_r;
  logic [DATA_WIDTH-1:0] dout;
  logic [NUM_OUT-1:0]    dout_v;
  logic [NUM_OUT-1:0]    dout_r;

  // Fork stage side
  modport slave (
    input  din, din_v, dout_r,
    output din_r, dout, dout_v
  );

  // Environment side: upstream FIFO and downstream consumers
  modport master (
    output din, din_v, dout_r,
    input  din_r, dout, dout_v
  );
endinterface

// File: rtl/d_fork_eager.sv
// Eager fork: holds one token and broadcasts it to NUM_OUT branches, each of
// which completes independently. The token retires once every branch has
// taken it, and a new token may be accepted in that same retire cycle.
//
// state      | meaning
// FORK_EMPTY | no token held, din_r=1
// FORK_HOLD  | token held on dout, unserved branches see dout_v
module d_fork_eager
  import cgra_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int NUM_OUT    = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  d_fork_eager_if.slave        io,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] tok_count
);

  fork_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [NUM_OUT-1:0]    sent_q, sent_d;
  logic [CNT_WIDTH-1:0]  tok_count_q, tok_count_d;

  logic                    hold_valid;
  logic [NUM_OUT-1:0]      dout_v;
  logic [NUM_OUT-1:0]      served_now;
  logic [MAX_FORK_OUT-1:0] sent_pad;
  logic [MAX_FORK_OUT-1:0] served_pad;
  logic                    done_now;
  logic                    din_r;

  // Handshake decode: per-branch valid from held state only, retire detect
  always_comb begin
    hold_valid = (state_q == FORK_HOLD);
    dout_v     = hold_valid ? ~sent_q : '0;
    served_now = dout_v & io.dout_r;
    sent_pad   = '1;
    sent_pad[NUM_OUT-1:0] = sent_q;
    served_pad = '0;
    served_pad[NUM_OUT-1:0] = served_now;
    done_now   = hold_valid & all_served(sent_pad, served_pad);
    din_r      = ~hold_valid | done_now;
  end

  // Next-state: accept, track served branches, retire and count
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    sent_d      = sent_q;
    tok_count_d = tok_count_q;
    case (state_q)
      FORK_EMPTY: begin
        if (io.din_v) begin
          hold_data_d = io.din;
          sent_d      = '0;
          state_d     = FORK_HOLD;
        end
      end
      FORK_HOLD: begin
        sent_d = sent_q | served_now;
        if (done_now) begin
          tok_count_d = tok_count_q + CNT_WIDTH'(1);
          sent_d      = '0;
          if (io.din_v) begin
            hold_data_d = io.din;
          end else begin
            state_d = FORK_EMPTY;
          end
        end
      end
      default: state_d = FORK_EMPTY;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FORK_EMPTY;
      hold_data_q <= '0;
      sent_q      <= '0;
      tok_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      sent_q      <= sent_d;
      tok_count_q <= tok_count_d;
    end
  end

  assign io.dout   = hold_data_q;
  assign io.dout_v = dout_v;
  assign io.din_r  = din_r;
  assign busy      = hold_valid;
  assign tok_count = tok_count_q;

endmodule

// File: tb/tb_d_fork_eager.sv
// Bench for the eager fork: directed table, corner sequences, random traffic.
module tb_d_fork_eager;

  localparam int DW = 32;
  localparam int NO = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          din_v;
  logic [NO-1:0] dout_r;

  logic        busy_a, busy_b;
  logic [15:0] tok_count_a;
  logic [3:0]  tok_count_b;

  d_fork_eager_if #(.DATA_WIDTH(DW), .NUM_OUT(NO)) if_a ();
  d_fork_eager_if #(.DATA_WIDTH(DW), .NUM_OUT(NO)) if_b ();

  assign if_a.din    = din;
  assign if_a.din_v  = din_v;
  assign if_a.dout_r = dout_r;
  assign if_b.din    = din;
  assign if_b.din_v  = din_v;
  assign if_b.dout_r = dout_r;

  d_fork_eager #(.DATA_WIDTH(DW), .NUM_OUT(NO), .CNT_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .io(if_a.slave),
    .busy(busy_a), .tok_count(tok_count_a));

  d_fork_eager #(.DATA_WIDTH(DW), .NUM_OUT(NO), .CNT_WIDTH(4)) dut_b (
    .clock(clock), .reset(reset), .io(if_b.slave),
    .busy(busy_b), .tok_count(tok_count_b));

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a held token, which branches have it, retired count.
  bit          m_have;
  logic [31:0] m_data;
  bit          m_got [NO];
  int          m_cnt;

  task automatic model_reset();
    m_have = 0; m_data = '0; m_cnt = 0;
    for (int i = 0; i < NO; i++) m_got[i] = 0;
  endtask

  function automatic int still_waiting();
    int n = 0;
    for (int i = 0; i < NO; i++) if (!m_got[i] && !dout_r[i]) n++;
    return n;
  endfunction

  task automatic check_model();
    logic [NO-1:0] e_v;
    for (int i = 0; i < NO; i++) e_v[i] = m_have && !m_got[i];
    chk("dout_v", 64'(if_a.dout_v), 64'(e_v));
    chk("din_r", 64'(if_a.din_r), 64'(!m_have || still_waiting() == 0));
    chk("dout", 64'(if_a.dout), 64'(m_data));
    chk("busy", 64'(busy_a), 64'(m_have));
    chk("tok_count", 64'(tok_count_a), 64'(m_cnt % 65536));
    chk("tok_count_w4", 64'(tok_count_b), 64'(m_cnt % 16));
  endtask

  task automatic advance();
    bit retire;
    retire = m_have && still_waiting() == 0;
    @(posedge clock);
    if (m_have) begin
      for (int i = 0; i < NO; i++) if (dout_r[i]) m_got[i] = 1;
      if (retire) begin
        m_cnt++;
        for (int i = 0; i < NO; i++) m_got[i] = 0;
        if (din_v) m_data = din;
        else m_have = 0;
      end
    end else if (din_v) begin
      m_have = 1; m_data = din;
      for (int i = 0; i < NO; i++) m_got[i] = 0;
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic dv, input logic [NO-1:0] r);
    din = d; din_v = dv; dout_r = r;
  endtask

  task automatic step(input logic [31:0] d, input logic dv, input logic [NO-1:0] r);
    drive(d, dv, r); #1; check_model(); advance();
  endtask

  task automatic do_reset();
    reset = 1'b1; drive('0, 1'b0, '0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [31:0]   din;
    logic          din_v;
    logic [NO-1:0] dout_r;
    logic [31:0]   e_dout;
    logic [NO-1:0] e_dout_v;
    logic          e_din_r;
    int            e_cnt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    reset = 1'b1;
    drive('0, 1'b0, '0);
    model_reset();

    // Single token, then 8 back-to-back tokens with all branches ready.
    v = '{32'hA5A5_0001, 1'b1, 2'b11, 32'h0, 2'b00, 1'b1, 0}; vecs.push_back(v);
    v = '{32'h0, 1'b0, 2'b11, 32'hA5A5_0001, 2'b11, 1'b1, 0}; vecs.push_back(v);
    v = '{32'h0, 1'b0, 2'b11, 32'hA5A5_0001, 2'b00, 1'b1, 1}; vecs.push_back(v);
    for (int k = 0; k < 8; k++) begin
      v.din = 32'h10 + k; v.din_v = 1'b1; v.dout_r = 2'b11; v.e_din_r = 1'b1;
      v.e_dout   = (k == 0) ? 32'hA5A5_0001 : 32'h10 + k - 1;
      v.e_dout_v = (k == 0) ? 2'b00 : 2'b11;
      v.e_cnt    = (k == 0) ? 1 : k;
      vecs.push_back(v);
    end
    v = '{32'h0, 1'b0, 2'b11, 32'h17, 2'b11, 1'b1, 8}; vecs.push_back(v);
    v = '{32'h0, 1'b0, 2'b11, 32'h17, 2'b00, 1'b1, 9}; vecs.push_back(v);

    @(posedge clock); #1;
    reset = 1'b0;

    foreach (vecs[n]) begin
      drive(vecs[n].din, vecs[n].din_v, vecs[n].dout_r);
      #1;
      chk($sformatf("vec%0d_dout", n), 64'(if_a.dout), 64'(vecs[n].e_dout));
      chk($sformatf("vec%0d_dout_v", n), 64'(if_a.dout_v), 64'(vecs[n].e_dout_v));
      chk($sformatf("vec%0d_din_r", n), 64'(if_a.din_r), 64'(vecs[n].e_din_r));
      chk($sformatf("vec%0d_cnt", n), 64'(tok_count_a), 64'(vecs[n].e_cnt));
      check_model();
      advance();
    end

    // Branch 0 served first, branch 1 later.
    step(32'h22, 1'b1, 2'b00);
    drive('0, 1'b0, 2'b01); #1;
    chk("split_c1_dout_v", 64'(if_a.dout_v), 64'(2'b11));
    chk("split_c1_din_r", 64'(if_a.din_r), 64'(1'b0));
    check_model(); advance();
    for (int c = 2; c <= 3; c++) begin
      drive('0, 1'b0, 2'b01); #1;
      chk("split_mid_dout_v", 64'(if_a.dout_v), 64'(2'b10));
      chk("split_mid_din_r", 64'(if_a.din_r), 64'(1'b0));
      check_model(); advance();
    end
    drive('0, 1'b0, 2'b10); #1;
    chk("split_c4_din_r", 64'(if_a.din_r), 64'(1'b1));
    check_model(); advance();
    drive('0, 1'b0, 2'b00); #1;
    chk("split_retired_cnt", 64'(tok_count_a), 64'(10));
    chk("split_idle_dout_v", 64'(if_a.dout_v), 64'(2'b00));
    advance();

    // Full stall with a pending upstream token, then release.
    step(32'h22, 1'b1, 2'b00);
    for (int c = 0; c < 10; c++) begin
      drive(32'h33, 1'b1, 2'b00); #1;
      chk("stall_dout", 64'(if_a.dout), 64'(32'h22));
      chk("stall_din_r", 64'(if_a.din_r), 64'(1'b0));
      chk("stall_cnt", 64'(tok_count_a), 64'(10));
      check_model(); advance();
    end
    drive(32'h33, 1'b1, 2'b11); #1;
    chk("release_din_r", 64'(if_a.din_r), 64'(1'b1));
    check_model(); advance();
    drive('0, 1'b0, 2'b11); #1;
    chk("release_dout", 64'(if_a.dout), 64'(32'h33));
    chk("release_dout_v", 64'(if_a.dout_v), 64'(2'b11));
    check_model(); advance();

    // Reset while holding a partly served token.
    step(32'h44, 1'b1, 2'b00);
    step(32'h0, 1'b0, 2'b01);
    do_reset();
    drive('0, 1'b0, 2'b00); #1;
    chk("rst_dout_v", 64'(if_a.dout_v), 64'(2'b00));
    chk("rst_dout", 64'(if_a.dout), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_cnt", 64'(tok_count_a), 64'(0));
    chk("rst_din_r", 64'(if_a.din_r), 64'(1'b1));
    advance();

    // Counter wrap on the 4-bit instance after 17 retires.
    for (int k = 0; k < 17; k++) step(32'h100 + k, 1'b1, 2'b11);
    step(32'h0, 1'b0, 2'b11);
    drive('0, 1'b0, 2'b00); #1;
    chk("wrap_cnt4", 64'(tok_count_b), 64'(1));
    chk("wrap_cnt16", 64'(tok_count_a), 64'(17));
    advance();

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      step($urandom, 1'($urandom_range(0, 1)), NO'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
